cr_meta_writer: RTL
===================

// Module: cr_meta_writer
// PURPOSE
//  Authorised hardware writer for the CR metadata region (META_BASE..META_END).
//  Optionally zero-fills the region, then streams word entries from a source into it.
//  Every write it issues is flagged with auth_wr so the region-integrity monitor exempts it.
//  The CPU never writes metadata directly; this block is the sole legitimate writer.
// PARAMETERS
//  META_BASE       16'h0160  first byte address of metadata region (word aligned)
//  META_END        16'h01FF  last byte address of region (inclusive); LAST = META_END-1
//  CLEAR_ON_START  1         1: zero-fill whole region before LOAD; 0: go straight to LOAD
// PORTS
//  clk        in   1   system clock, all state on posedge
//  reset      in   1   asynchronous, active-high; clears all state and outputs immediately
//  start      in   1   one-cycle pulse; begins a session (honoured in IDLE or DONE only)
//  in_valid   in   1   source entry valid
//  in_ready   out  1   block accepts entry (transfer = in_valid & in_ready)
//  in_data    in   16  entry word
//  in_last    in   1   qualifies final entry of session
//  bus_req    out  1   request memory write port from arbiter
//  bus_gnt    in   1   grant; no write issued in a cycle where bus_gnt=0
//  data_addr  out  16  write byte address (registered)
//  data_out   out  16  write data (registered)
//  data_wr    out  1   write strobe, single-cycle pulse per word (registered)
//  auth_wr    out  1   identical to data_wr, same cycle; consumed by integrity monitor
//  busy       out  1   1 in CLEAR or LOAD
//  done       out  1   1 in DONE, held until next start
//  error      out  1   1 in ERR, sticky until reset
//  count      out  16  entries written this session
// BEHAVIOUR
//  Reset: state=IDLE, ptr=META_BASE, count=0; all outputs 0.
//  States: IDLE, CLEAR, LOAD, DONE, ERR.
//  IDLE/DONE + start: ptr<=META_BASE, count<=0, done<=0; -> CLEAR if CLEAR_ON_START else LOAD.
//  start in CLEAR/LOAD/ERR ignored.
//  bus_req = busy. CLEAR: each cycle with bus_gnt: issue write(ptr,16'h0000), ptr+=2;
//   write at LAST -> ptr<=META_BASE, -> LOAD. in_ready=0 throughout CLEAR.
//  LOAD: in_ready = bus_gnt. On transfer: issue write(ptr,in_data), count+=1, ptr+=2.
//   in_last on transfer -> DONE (also when at LAST). Transfer at LAST without in_last -> ERR.
//  Write issue: data_addr/data_out/data_wr/auth_wr registered; pulse appears the cycle
//   after the accepting edge; data_wr=auth_wr=0 when no write; addr/data hold last value.
//  done/error asserted the cycle after the final/overflowing transfer, with its write pulse.
//  bus_gnt low: stall; ptr, count, state hold; no write, in_ready=0.
//  ERR: in_ready=0, bus_req=0, no further writes; only reset exits.
//  Reset mid-session: outputs drop asynchronously; partially written memory is not rolled back.
//  ptr never exceeds LAST; no write outside META_BASE..LAST is ever issued.
//  count wraps never (max 80 with defaults).
// TESTING
//  T1 reset, CLEAR_ON_START=1, gnt=1, start -> 80 zero writes 0x0160..0x01FE, auth_wr=data_wr each, then LOAD.
//  T2 LOAD 0xAAAA,0xBBBB,0xCCCC(last) -> writes @0x0160/0x0162/0x0164, count=3, done=1, busy=0.
//  T3 bus_gnt=0 for 5 cycles mid-LOAD -> in_ready=0, no data_wr; resumes at next address, no gap/dup.
//  T4 81 entries, no in_last -> 80 writes, error=1 after write @0x01FE, in_ready=0, start ignored.
//  T5 reset asserted mid-CLEAR between edges -> all outputs 0 immediately; new start restarts @0x0160.
//  T6 start during LOAD ignored; start in DONE -> done=0, count=0, new session from META_BASE.

Source files
------------

// File: rtl/cr_meta_writer_if.sv
// Handshake and write-port bundle for cr_meta_writer.
// The slave modport is the writer itself; master is whoever drives it (source/arbiter side).
interface cr_meta_writer_if;
    localparam int unsigned DW = 16;

    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          bus_req;
    logic          bus_gnt;
    logic [DW-1:0] data_addr;
    logic [DW-1:0] data_out;
    logic          data_wr;
    logic          auth_wr;
    logic          busy;
    logic          done;
    logic          error;
    logic [DW-1:0] count;

    modport master (
        output start, in_valid, in_data, in_last, bus_gnt,
        input  in_ready, bus_req, data_addr, data_out, data_wr, auth_wr,
               busy, done, error, count
    );

    modport slave (
        input  start, in_valid, in_data, in_last, bus_gnt,
        output in_ready, bus_req, data_addr, data_out, data_wr, auth_wr,
               busy, done, error, count
    );
endinterface

// File: rtl/cr_meta_writer.sv
// Sole authorised writer of the CR metadata region: optional zero-fill, then stream
// source entries into consecutive words, tagging every write with auth_wr.
module cr_meta_writer #(
    parameter logic [15:0] META_BASE      = 16'h0160,
    parameter logic [15:0] META_END       = 16'h01FF,
    parameter bit          CLEAR_ON_START = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    cr_meta_writer_if.slave   bus
);
    localparam int unsigned DW   = 16;
    localparam logic [DW-1:0] LAST = META_END - DW'(1);
    localparam logic [DW-1:0] STEP = DW'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state_q;
    logic [DW-1:0] ptr_q;
    logic [DW-1:0] count_q;
    logic [DW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          wr_q;
    logic          busy_q;
    logic          done_q;
    logic          error_q;

    logic          load_ready;
    logic          xfer;

    // in_ready must track bus_gnt in the same cycle for the handshake to work
    assign load_ready = (state_q == S_LOAD) && bus.bus_gnt;
    assign xfer       = load_ready && bus.in_valid;

    assign bus.in_ready  = load_ready;
    assign bus.bus_req   = busy_q;
    assign bus.data_addr = addr_q;
    assign bus.data_out  = wdata_q;
    assign bus.data_wr   = wr_q;
    assign bus.auth_wr   = wr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.count     = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= META_BASE;
            count_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            wr_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        ptr_q   <= META_BASE;
                        count_q <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= CLEAR_ON_START ? S_CLEAR : S_LOAD;
                    end
                end
                S_CLEAR: begin
                    if (bus.bus_gnt) begin
                        addr_q  <= ptr_q;
                        wdata_q <= '0;
                        wr_q    <= 1'b1;
                        if (ptr_q == LAST) begin
                            ptr_q   <= META_BASE;
                            state_q <= S_LOAD;
                        end else begin
                            ptr_q <= ptr_q + STEP;
                        end
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        addr_q  <= ptr_q;
                        wdata_q <= bus.in_data;
                        wr_q    <= 1'b1;
                        count_q <= count_q + DW'(1);
                        // in_last wins over overflow, so a full region ending on LAST is legal
                        if (bus.in_last) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else if (ptr_q == LAST) begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            ptr_q <= ptr_q + STEP;
                        end
                    end
                end
                S_ERR: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule
